pipeline_hazard_ctrl: RTL

//   Sequences the 5-stage pipeline: detects load-use hazards, applies EX-stage redirect flushes,

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard / halt sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Value of x17 that turns ECALL into a halt request.
    localparam int unsigned ECALL_HALT_CODE = 10;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: flags an ID instruction reading the register an EX load is about to write.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides what a hazard stalls.
module pipeline_hazard_ctrl_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    output logic              load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it can never create a dependency.
    always_comb begin
        rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, EX redirect flush, dmem freeze, ECALL(x17==10) drain-then-halt.
// Latency: stall/flush/freeze controls are same-cycle; is_halted_o rises DRAIN_CYCLES+1 cycles after the ECALL sits in ID.
// Backpressure: dmem_busy_i freezes everything (also pauses the drain count); optional counters behind HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_AW       = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_is_ecall_i,
    input  logic              id_x17_is_10_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_redirect_i,
    input  logic              dmem_busy_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_freeze_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_count_o,
`endif
    output logic              is_halted_o
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .load_use_o    (load_use)
    );

    // State and drain-counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and pipeline control decode; RUN branches are in strict priority order.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_busy_i) begin
                    pipe_freeze_o = 1'b1;
                end else if (ex_redirect_i) begin
                    // Wrong-path IF and ID instructions are both squashed, an ECALL in ID included.
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                end else if (load_use) begin
                    // One bubble suffices: next cycle the load is in MEM and forwarding covers it.
                    idex_bubble_o = 1'b1;
                end else if (id_is_ecall_i && id_x17_is_10_i) begin
                    // Stop fetching but let the ECALL itself advance into EX.
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Nothing older than the ECALL can redirect, so ex_redirect_i is ignored here.
                idex_bubble_o = 1'b1;
                pipe_freeze_o = dmem_busy_i;
                if (!dmem_busy_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                idex_bubble_o = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Halt flag is a decode of the registered state, so it rises on the cycle after entry.
    assign is_halted_o = (state_q == ST_HALTED);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Performance counters: only RUN-state events count, so both freeze once halted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else if (state_q == ST_RUN) begin
            if (load_use || dmem_busy_i) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ex_redirect_i) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule
